mux_scan_ctrl: RTL and testbench

Sequencer that drives the select and data inputs of the 8:1 mux stage (MUX81) and consumes its single-bit output. On a START request it latches an 8-bit word, presents it on the mux data bus, steps SEL through all eight positions with a programmable dwell, and samples the mux output at each position. The samples are emitted as a serial bit stream and reassembled into a byte. A final compare against the latched word gives a mux self-check (MATCH).

---
 rtl/mux_scan_ctrl_if.sv | 26 ++
 rtl/mux_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the mux scan sequencer and its 8:1 mux stage / requester.
// The slave side is the sequencer; the master side drives requests and the mux output.
interface mux_scan_ctrl_if;
    logic       start;
    logic       abort;
    logic [7:0] data_in;
    logic       mux_out;
    logic [7:0] mux_in;
    logic [2:0] sel;
    logic       busy;
    logic       ser_out;
    logic       ser_valid;
    logic [7:0] rx_data;
    logic       done;
    logic       match;

    modport master (
        output start, abort, data_in, mux_out,
        input  mux_in, sel, busy, ser_out, ser_valid, rx_data, done, match
    );

    modport slave (
        input  start, abort, data_in, mux_out,
        output mux_in, sel, busy, ser_out, ser_valid, rx_data, done, match
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Walks the 8:1 mux select across all inputs, samples the mux output per position,
// streams the samples serially and rebuilds the byte for a self-check compare.
module mux_scan_ctrl #(
    parameter int DWELL     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.slave bus
);
    localparam int            CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [2:0]    SEL_FIRST  = LSB_FIRST ? 3'd0 : 3'd7;

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] dwell_reg;
    logic [2:0]    idx_reg;
    logic [2:0]    sel_reg;
    logic [7:0]    mux_in_reg;
    logic [7:0]    rx_reg;
    logic [7:0]    rx_next;
    logic          ser_out_reg;
    logic          ser_valid_reg;
    logic          match_reg;
    logic          busy;
    logic          done;
    logic          accept;
    logic          sample;
    logic          last_sample;

    assign accept      = (state_reg == IDLE) && bus.start && !bus.abort;
    assign sample      = (state_reg == SCAN) && !bus.abort && (dwell_reg == DWELL_LAST);
    assign last_sample = sample && (idx_reg == 3'd7);

    // Byte with the current sample merged in; also feeds the final compare.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rx
            assign rx_next[gi] = (sample && (sel_reg == 3'(gi))) ? bus.mux_out : rx_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SCAN;
            SCAN:    if (bus.abort) state_next = IDLE;
                     else if (last_sample) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_reg     <= '0;
            idx_reg       <= 3'd0;
            sel_reg       <= 3'd0;
            mux_in_reg    <= 8'd0;
            rx_reg        <= 8'd0;
            ser_out_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
            match_reg     <= 1'b0;
        end else begin
            ser_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        mux_in_reg <= bus.data_in;
                        rx_reg     <= 8'd0;
                        match_reg  <= 1'b0;
                        idx_reg    <= 3'd0;
                        dwell_reg  <= '0;
                        sel_reg    <= SEL_FIRST;
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        sel_reg   <= 3'd0;
                        match_reg <= 1'b0;
                        dwell_reg <= '0;
                        idx_reg   <= 3'd0;
                    end else if (sample) begin
                        rx_reg        <= rx_next;
                        ser_out_reg   <= bus.mux_out;
                        ser_valid_reg <= 1'b1;
                        dwell_reg     <= '0;
                        idx_reg       <= idx_reg + 3'd1;
                        sel_reg       <= LSB_FIRST ? (sel_reg + 3'd1) : (sel_reg - 3'd1);
                        if (idx_reg == 3'd7) begin
                            match_reg <= (rx_next == mux_in_reg);
                        end
                    end else begin
                        dwell_reg <= dwell_reg + CW'(1);
                    end
                end
                FIN: begin
                    sel_reg <= 3'd0;
                    if (bus.abort) begin
                        match_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mux_in    = mux_in_reg;
    assign bus.sel       = sel_reg;
    assign bus.busy      = busy;
    assign bus.ser_out   = ser_out_reg;
    assign bus.ser_valid = ser_valid_reg;
    assign bus.rx_data   = rx_reg;
    assign bus.done      = done;
    assign bus.match     = match_reg;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: an LSB-first DWELL=4 instance and an MSB-first
// DWELL=2 instance, each looped back through a behavioural 8:1 mux.
module tb_mux_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;
    logic stuck3;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl_if ifa ();
    mux_scan_ctrl_if ifb ();

    // Mux models; instance A can have input 3 stuck at 0.
    assign ifa.mux_out = (stuck3 && (ifa.sel == 3'd3)) ? 1'b0 : ifa.mux_in[ifa.sel];
    assign ifb.mux_out = ifb.mux_in[ifb.sel];

    mux_scan_ctrl #(.DWELL(4), .LSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (ifa.slave)
    );

    mux_scan_ctrl #(.DWELL(2), .LSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ifb.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [23:0] obs;
        #3;
        n_checks++;
        obs = {ifa.mux_in, ifa.sel, ifa.rx_data, ifa.busy, ifa.ser_out, ifa.ser_valid, ifa.done, ifa.match};
        if (obs !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_a_outputs: got %h expected 000000", obs);
        end
        n_checks++;
        obs = {ifb.mux_in, ifb.sel, ifb.rx_data, ifb.busy, ifb.ser_out, ifb.ser_valid, ifb.done, ifb.match};
        if (obs !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_b_outputs: got %h expected 000000", obs);
        end
        tick();
        tick();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        tick();
        // Mid-scan asynchronous reset while SEL=3.
        ifa.data_in = 8'hA5;
        ifa.start   = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (13) tick();
        n_checks++;
        if (ifa.sel !== 3'd3 || ifa.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_sel: sel=%0d busy=%b expected sel=3 busy=1", ifa.sel, ifa.busy);
        end
        #3;
        rst_n_a = 1'b0;
        #1;
        n_checks++;
        obs = {ifa.mux_in, ifa.sel, ifa.rx_data, ifa.busy, ifa.ser_out, ifa.ser_valid, ifa.done, ifa.match};
        if (obs !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_async_clear: got %h expected 000000", obs);
        end
        #2;
        rst_n_a = 1'b1;
        tick();
        n_checks++;
        if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.sel !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b done=%b sel=%0d expected 0 0 0",
                     ifa.busy, ifa.done, ifa.sel);
        end
        $display("reset: async clear mid-scan, idle after release");
    endtask

    task automatic scan_a(input string name, input logic [7:0] word, input logic [7:0] exp_rx,
                          input logic exp_match, input logic stuck, input logic midscan);
        int dones = 0;
        logic [2:0] exp_flags;
        logic [2:0] obs_flags;
        stuck3      = stuck;
        ifa.data_in = word;
        ifa.start   = 1'b1;
        tick();
        ifa.start = 1'b0;
        n_checks++;
        if (ifa.busy !== 1'b1 || ifa.sel !== 3'd0 || ifa.rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_accept: busy=%b sel=%0d rx=%h expected 1 0 00", name, ifa.busy, ifa.sel, ifa.rx_data);
        end
        for (int c = 1; c <= 33; c++) begin
            if (midscan && c == 10) begin
                ifa.start   = 1'b1;
                ifa.data_in = 8'h00;
            end
            if (midscan && c == 12) ifa.start = 1'b0;
            tick();
            if (ifa.done === 1'b1) dones++;
            exp_flags = {(c % 4 == 0) && (c <= 32), c <= 32, c == 32};
            obs_flags = {ifa.ser_valid, ifa.busy, ifa.done};
            n_checks++;
            if (obs_flags !== exp_flags) begin
                n_fail++;
                $display("FAIL %s_flags c=%0d: valid/busy/done=%b expected %b", name, c, obs_flags, exp_flags);
            end
            if (exp_flags[2]) begin
                n_checks++;
                if (ifa.ser_out !== exp_rx[c/4-1]) begin
                    n_fail++;
                    $display("FAIL %s_ser_out c=%0d: got %b expected %b", name, c, ifa.ser_out, exp_rx[c/4-1]);
                end
            end
            if (c < 32) begin
                n_checks++;
                if (ifa.sel !== 3'(c/4)) begin
                    n_fail++;
                    $display("FAIL %s_sel c=%0d: got %0d expected %0d", name, c, ifa.sel, c/4);
                end
            end
        end
        n_checks++;
        if (ifa.rx_data !== exp_rx || ifa.match !== exp_match || ifa.mux_in !== word || dones != 1 || ifa.sel !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_result: rx=%h match=%b mux_in=%h dones=%0d sel=%0d expected rx=%h match=%b mux_in=%h dones=1 sel=0",
                     name, ifa.rx_data, ifa.match, ifa.mux_in, dones, ifa.sel, exp_rx, exp_match, word);
        end
        stuck3 = 1'b0;
        $display("%s: word=%h rx=%h match=%b dones=%0d", name, word, ifa.rx_data, ifa.match, dones);
    endtask

    task automatic test_loopback;
        scan_a("loopback", 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_fault;
        scan_a("fault", 8'hFF, 8'hF7, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_robustness;
        scan_a("robust", 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_abort;
        int dones = 0;
        ifa.start   = 1'b1;
        ifa.abort   = 1'b1;
        ifa.data_in = 8'h55;
        tick();
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        n_checks++;
        if (ifa.busy !== 1'b0 || ifa.mux_in !== 8'h3C) begin
            n_fail++;
            $display("FAIL abort_idle_start: busy=%b mux_in=%h expected 0 3c", ifa.busy, ifa.mux_in);
        end
        ifa.data_in = 8'hD6;
        ifa.start   = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (ifa.done === 1'b1) dones++;
        end
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;
        n_checks++;
        if (ifa.busy !== 1'b0 || ifa.sel !== 3'd0 || ifa.ser_valid !== 1'b0 || ifa.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b sel=%0d valid=%b done=%b expected 0 0 0 0",
                     ifa.busy, ifa.sel, ifa.ser_valid, ifa.done);
        end
        n_checks++;
        if (ifa.rx_data !== 8'h16 || ifa.match !== 1'b0 || ifa.mux_in !== 8'hD6) begin
            n_fail++;
            $display("FAIL abort_partial: rx=%h match=%b mux_in=%h expected 16 0 d6",
                     ifa.rx_data, ifa.match, ifa.mux_in);
        end
        repeat (6) begin
            tick();
            if (ifa.done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0 || ifa.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: dones=%0d busy=%b expected 0 0", dones, ifa.busy);
        end
        $display("abort: partial rx=%h, dones=%0d", ifa.rx_data, dones);
        scan_a("after_abort", 8'h81, 8'h81, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        logic [2:0] exp_flags;
        logic [2:0] obs_flags;
        ifb.data_in = 8'h01;
        ifb.start   = 1'b1;
        tick();
        for (int c = 1; c <= 17; c++) begin
            tick();
            exp_flags = {(c % 2 == 0) && (c <= 16), c <= 16, c == 16};
            obs_flags = {ifb.ser_valid, ifb.busy, ifb.done};
            n_checks++;
            if (obs_flags !== exp_flags) begin
                n_fail++;
                $display("FAIL order_flags c=%0d: valid/busy/done=%b expected %b", c, obs_flags, exp_flags);
            end
            if (exp_flags[2]) begin
                n_checks++;
                if (ifb.ser_out !== (c == 16)) begin
                    n_fail++;
                    $display("FAIL order_ser_out c=%0d: got %b expected %b", c, ifb.ser_out, c == 16);
                end
            end
            if (c < 16) begin
                n_checks++;
                if (ifb.sel !== 3'(7 - c/2)) begin
                    n_fail++;
                    $display("FAIL order_sel c=%0d: got %0d expected %0d", c, ifb.sel, 7 - c/2);
                end
            end
        end
        n_checks++;
        if (ifb.rx_data !== 8'h01 || ifb.match !== 1'b1 || ifb.sel !== 3'd0) begin
            n_fail++;
            $display("FAIL order_result: rx=%h match=%b sel=%0d expected 01 1 0", ifb.rx_data, ifb.match, ifb.sel);
        end
        ifb.data_in = 8'h80;
        tick();
        ifb.start = 1'b0;
        n_checks++;
        if (ifb.busy !== 1'b1 || ifb.sel !== 3'd7 || ifb.mux_in !== 8'h80 || ifb.match !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b sel=%0d mux_in=%h match=%b expected 1 7 80 0",
                     ifb.busy, ifb.sel, ifb.mux_in, ifb.match);
        end
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (ifb.done === 1'b1) dones++;
        end
        n_checks++;
        if (ifb.rx_data !== 8'h80 || ifb.match !== 1'b1 || ifb.busy !== 1'b0 || dones != 1) begin
            n_fail++;
            $display("FAIL b2b_result: rx=%h match=%b busy=%b dones=%0d expected 80 1 0 1",
                     ifb.rx_data, ifb.match, ifb.busy, dones);
        end
        $display("back_to_back: rx=%h match=%b dones=%0d", ifb.rx_data, ifb.match, dones);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_a     = 1'b0;
        rst_n_b     = 1'b0;
        stuck3      = 1'b0;
        ifa.start   = 1'b0;
        ifa.abort   = 1'b0;
        ifa.data_in = 8'h00;
        ifb.start   = 1'b0;
        ifb.abort   = 1'b0;
        ifb.data_in = 8'h00;
        test_reset();
        test_loopback();
        test_fault();
        test_robustness();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
